// File: rtl/ps_filter_sched.sv
// Frame scheduler: counts filter input reads, stalls at the frame end, then drains, flushes and applies the staged config.
// Latency: frame end to o_hold release is FLUSH_CYCLES+3 cycles with the output empty; o_hold asserts combinationally on the last read.
module ps_filter_sched #(
    parameter int LINE_LENGTH   = 640,
    parameter int LINE_COUNT    = 480,
    parameter int FLUSH_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int THRESH_WIDTH  = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_cfg_valid,
    input  logic                    i_cfg_enable,
    input  logic [THRESH_WIDTH-1:0] i_cfg_threshold,
    input  logic                    i_pix_rd,
    input  logic                    i_obuf_empty,
    output logic                    o_enable,
    output logic [THRESH_WIDTH-1:0] o_threshold,
    output logic                    o_hold,
    output logic                    o_flush,
    output logic                    o_cfg_pending,
    output logic                    o_frame_done,
    output logic [15:0]             o_frame_count,
    output logic [1:0]              o_err
);

    localparam int CW = (LINE_LENGTH > 1)   ? $clog2(LINE_LENGTH)   : 1;
    localparam int RW = (LINE_COUNT > 1)    ? $clog2(LINE_COUNT)    : 1;
    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int FW = (FLUSH_CYCLES > 1)  ? $clog2(FLUSH_CYCLES)  : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(LINE_LENGTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(LINE_COUNT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH, APPLY} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DW-1:0]           drain_cnt;
    logic [FW-1:0]           flush_cnt;
    logic                    shadow_enable;
    logic [THRESH_WIDTH-1:0] shadow_threshold;
    logic                    last_pix;
    logic                    drain_expired;

    always_comb begin
        state_nxt     = state;
        last_pix      = (row == ROW_LAST) && (col == COL_LAST);
        drain_expired = (drain_cnt == DRAIN_LAST);
        case (state)
            RUN:     if (i_pix_rd && last_pix) state_nxt = DRAIN;
            DRAIN:   if (i_obuf_empty || drain_expired) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = APPLY;
            APPLY:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        // Stall in the same cycle as the last read so the filter's registered read cannot overshoot.
        o_hold = (state != RUN) || (i_pix_rd && last_pix);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state            <= RUN;
            col              <= '0;
            row              <= '0;
            drain_cnt        <= '0;
            flush_cnt        <= '0;
            shadow_enable    <= 1'b0;
            shadow_threshold <= '0;
            o_enable         <= 1'b0;
            o_threshold      <= '0;
            o_flush          <= 1'b0;
            o_cfg_pending    <= 1'b0;
            o_frame_done     <= 1'b0;
            o_frame_count    <= '0;
            o_err            <= '0;
        end else begin
            state        <= state_nxt;
            o_flush      <= (state_nxt == FLUSH);
            o_frame_done <= (state_nxt == APPLY);

            if (state == RUN && i_pix_rd) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;

            if (state == DRAIN && !i_obuf_empty && drain_expired) o_err[0] <= 1'b1;
            if (state != RUN && i_pix_rd) o_err[1] <= 1'b1;

            if (i_cfg_valid) begin
                shadow_enable    <= i_cfg_enable;
                shadow_threshold <= i_cfg_threshold;
            end

            // A request landing in APPLY bypasses the shadow and never shows as pending.
            if (state == APPLY) begin
                if (i_cfg_valid) begin
                    o_enable    <= i_cfg_enable;
                    o_threshold <= i_cfg_threshold;
                end else if (o_cfg_pending) begin
                    o_enable    <= shadow_enable;
                    o_threshold <= shadow_threshold;
                end
                o_cfg_pending <= 1'b0;
                o_frame_count <= o_frame_count + 16'd1;
            end else if (i_cfg_valid) begin
                o_cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps_filter_sched.sv
// Directed bench for ps_filter_sched with a 4x2 frame, 2-cycle flush and 16-cycle drain timeout.
module tb_ps_filter_sched;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic        i_cfg_enable = 1'b0;
    logic [23:0] i_cfg_threshold = '0;
    logic        i_pix_rd = 1'b0;
    logic        i_obuf_empty = 1'b1;
    logic        o_enable;
    logic [23:0] o_threshold;
    logic        o_hold;
    logic        o_flush;
    logic        o_cfg_pending;
    logic        o_frame_done;
    logic [15:0] o_frame_count;
    logic [1:0]  o_err;

    int n_checks = 0;
    int n_fail   = 0;

    ps_filter_sched #(
        .LINE_LENGTH(4), .LINE_COUNT(2), .FLUSH_CYCLES(2),
        .DRAIN_TIMEOUT(16), .THRESH_WIDTH(24)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_cfg_valid(i_cfg_valid), .i_cfg_enable(i_cfg_enable), .i_cfg_threshold(i_cfg_threshold),
        .i_pix_rd(i_pix_rd), .i_obuf_empty(i_obuf_empty),
        .o_enable(o_enable), .o_threshold(o_threshold), .o_hold(o_hold), .o_flush(o_flush),
        .o_cfg_pending(o_cfg_pending), .o_frame_done(o_frame_done),
        .o_frame_count(o_frame_count), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reads(input int n);
        for (int i = 0; i < n; i++) begin
            i_pix_rd = 1'b1;
            tick();
        end
        i_pix_rd = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        n_checks++; if (o_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %0h expected 0", o_enable); end
        n_checks++; if (o_threshold !== 24'h0) begin n_fail++; $display("FAIL reset_threshold: got %0h expected 0", o_threshold); end
        n_checks++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0h expected 0", o_flush); end
        n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h expected 0", o_frame_done); end
        n_checks++; if (o_frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0h expected 0", o_frame_count); end
        n_checks++; if (o_cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", o_cfg_pending); end
        n_checks++; if (o_err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", o_err); end
        n_checks++; if (o_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %0h expected 0", o_hold); end
        #9 i_rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame;
        i_obuf_empty = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_pix_rd = 1'b1;
            @(negedge i_clk);
            n_checks++; if (o_hold !== (i == 7)) begin n_fail++; $display("FAIL basic_hold_read%0d: got %0h expected %0h", i, o_hold, (i == 7)); end
            tick();
        end
        i_pix_rd = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            n_checks++; if (o_flush !== (k >= 2 && k <= 3)) begin n_fail++; $display("FAIL basic_flush_k%0d: got %0h expected %0h", k, o_flush, (k >= 2 && k <= 3)); end
            n_checks++; if (o_frame_done !== (k == 4)) begin n_fail++; $display("FAIL basic_done_k%0d: got %0h expected %0h", k, o_frame_done, (k == 4)); end
            n_checks++; if (o_hold !== (k < 5)) begin n_fail++; $display("FAIL basic_hold_k%0d: got %0h expected %0h", k, o_hold, (k < 5)); end
            tick();
        end
        @(negedge i_clk);
        n_checks++; if (o_frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", o_frame_count); end
        n_checks++; if (o_err !== 2'b00) begin n_fail++; $display("FAIL basic_err: got %0h expected 0", o_err); end
        tick();
    endtask

    task automatic test_cfg_midframe;
        do_reads(3);
        i_cfg_valid = 1'b1; i_cfg_enable = 1'b1; i_cfg_threshold = 24'h000100;
        tick();
        i_cfg_valid = 1'b0; i_cfg_enable = 1'b0; i_cfg_threshold = 24'h0;
        @(negedge i_clk);
        n_checks++; if (o_cfg_pending !== 1'b1) begin n_fail++; $display("FAIL cfg_pending_set: got %0h expected 1", o_cfg_pending); end
        n_checks++; if (o_enable !== 1'b0) begin n_fail++; $display("FAIL cfg_enable_early: got %0h expected 0", o_enable); end
        n_checks++; if (o_threshold !== 24'h0) begin n_fail++; $display("FAIL cfg_thr_early: got %0h expected 0", o_threshold); end
        tick();
        do_reads(5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge i_clk);
            if (k == 4) begin
                n_checks++; if (o_frame_done !== 1'b1) begin n_fail++; $display("FAIL cfg_done: got %0h expected 1", o_frame_done); end
                n_checks++; if (o_enable !== 1'b0) begin n_fail++; $display("FAIL cfg_enable_apply: got %0h expected 0", o_enable); end
                n_checks++; if (o_cfg_pending !== 1'b1) begin n_fail++; $display("FAIL cfg_pending_apply: got %0h expected 1", o_cfg_pending); end
            end
            if (k == 5) begin
                n_checks++; if (o_enable !== 1'b1) begin n_fail++; $display("FAIL cfg_enable_new: got %0h expected 1", o_enable); end
                n_checks++; if (o_threshold !== 24'h000100) begin n_fail++; $display("FAIL cfg_thr_new: got %0h expected 000100", o_threshold); end
                n_checks++; if (o_cfg_pending !== 1'b0) begin n_fail++; $display("FAIL cfg_pending_clr: got %0h expected 0", o_cfg_pending); end
                n_checks++; if (o_frame_count !== 16'd2) begin n_fail++; $display("FAIL cfg_count: got %0d expected 2", o_frame_count); end
            end
            tick();
        end
    endtask

    task automatic test_drain_timeout;
        i_obuf_empty = 1'b0;
        do_reads(8);
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (k <= 17) begin
                n_checks++; if (o_flush !== (k == 17)) begin n_fail++; $display("FAIL timeout_flush_k%0d: got %0h expected %0h", k, o_flush, (k == 17)); end
            end
            if (k == 16) begin
                n_checks++; if (o_err !== 2'b00) begin n_fail++; $display("FAIL timeout_err_early: got %0h expected 0", o_err); end
            end
            if (k == 17) begin
                n_checks++; if (o_err !== 2'b01) begin n_fail++; $display("FAIL timeout_err: got %0h expected 1", o_err); end
                i_obuf_empty = 1'b1;
            end
            if (k == 19) begin
                n_checks++; if (o_frame_done !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got %0h expected 1", o_frame_done); end
            end
            if (k == 20) begin
                n_checks++; if (o_frame_count !== 16'd3) begin n_fail++; $display("FAIL timeout_count: got %0d expected 3", o_frame_count); end
                n_checks++; if (o_hold !== 1'b0) begin n_fail++; $display("FAIL timeout_hold: got %0h expected 0", o_hold); end
                n_checks++; if (o_err !== 2'b01) begin n_fail++; $display("FAIL timeout_err_sticky: got %0h expected 1", o_err); end
            end
            tick();
        end
    endtask

    task automatic test_read_in_flush;
        do_reads(8);
        tick();
        i_pix_rd = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL rdflush_flush: got %0h expected 1", o_flush); end
        n_checks++; if (o_hold !== 1'b1) begin n_fail++; $display("FAIL rdflush_hold: got %0h expected 1", o_hold); end
        tick();
        i_pix_rd = 1'b0;
        @(negedge i_clk);
        n_checks++; if (o_err !== 2'b11) begin n_fail++; $display("FAIL rdflush_err: got %0h expected 3", o_err); end
        tick();
        tick();
        @(negedge i_clk);
        n_checks++; if (o_frame_count !== 16'd4) begin n_fail++; $display("FAIL rdflush_count1: got %0d expected 4", o_frame_count); end
        tick();
        for (int i = 0; i < 8; i++) begin
            i_pix_rd = 1'b1;
            @(negedge i_clk);
            n_checks++; if (o_hold !== (i == 7)) begin n_fail++; $display("FAIL rdflush_hold_read%0d: got %0h expected %0h", i, o_hold, (i == 7)); end
            tick();
        end
        i_pix_rd = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge i_clk);
            n_checks++; if (o_frame_done !== (k == 4)) begin n_fail++; $display("FAIL rdflush_done_k%0d: got %0h expected %0h", k, o_frame_done, (k == 4)); end
            tick();
        end
        @(negedge i_clk);
        n_checks++; if (o_frame_count !== 16'd5) begin n_fail++; $display("FAIL rdflush_count2: got %0d expected 5", o_frame_count); end
        tick();
    endtask

    task automatic test_cfg_in_apply;
        do_reads(8);
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) begin
                i_cfg_valid = 1'b1; i_cfg_enable = 1'b0; i_cfg_threshold = 24'hABCDEF;
            end
            @(negedge i_clk);
            n_checks++; if (o_cfg_pending !== 1'b0) begin n_fail++; $display("FAIL apply_pending_k%0d: got %0h expected 0", k, o_cfg_pending); end
            if (k == 4) begin
                n_checks++; if (o_frame_done !== 1'b1) begin n_fail++; $display("FAIL apply_done: got %0h expected 1", o_frame_done); end
            end
            if (k == 5) begin
                n_checks++; if (o_threshold !== 24'hABCDEF) begin n_fail++; $display("FAIL apply_thr: got %0h expected abcdef", o_threshold); end
                n_checks++; if (o_enable !== 1'b0) begin n_fail++; $display("FAIL apply_enable: got %0h expected 0", o_enable); end
                n_checks++; if (o_frame_count !== 16'd6) begin n_fail++; $display("FAIL apply_count: got %0d expected 6", o_frame_count); end
            end
            tick();
            i_cfg_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset;
        do_reads(5);
        #2 i_rstn = 1'b0;
        #1;
        n_checks++; if (o_threshold !== 24'h0) begin n_fail++; $display("FAIL arst_threshold: got %0h expected 0", o_threshold); end
        n_checks++; if (o_frame_count !== 16'h0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", o_frame_count); end
        n_checks++; if (o_err !== 2'b00) begin n_fail++; $display("FAIL arst_err: got %0h expected 0", o_err); end
        n_checks++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL arst_flush: got %0h expected 0", o_flush); end
        n_checks++; if (o_hold !== 1'b0) begin n_fail++; $display("FAIL arst_hold: got %0h expected 0", o_hold); end
        n_checks++; if (o_cfg_pending !== 1'b0) begin n_fail++; $display("FAIL arst_pending: got %0h expected 0", o_cfg_pending); end
        @(negedge i_clk);
        #1 i_rstn = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            i_pix_rd = 1'b1;
            @(negedge i_clk);
            n_checks++; if (o_hold !== (i == 7)) begin n_fail++; $display("FAIL arst_hold_read%0d: got %0h expected %0h", i, o_hold, (i == 7)); end
            tick();
        end
        i_pix_rd = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge i_clk);
            n_checks++; if (o_frame_done !== (k == 4)) begin n_fail++; $display("FAIL arst_done_k%0d: got %0h expected %0h", k, o_frame_done, (k == 4)); end
            tick();
        end
        @(negedge i_clk);
        n_checks++; if (o_frame_count !== 16'd1) begin n_fail++; $display("FAIL arst_count_after: got %0d expected 1", o_frame_count); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_cfg_midframe();
        test_drain_timeout();
        test_read_in_flush();
        test_cfg_in_apply();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
